// File: rtl/addsub_pipe.sv
// Segmented pipelined adder/subtractor: one SEG-bit slice per stage, look-ahead inside each slice.
// Define ADDSUB_SAT_EN to clamp overflowing results to the signed extreme; default build wraps.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int L = WIDTH / SEG;
`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [L-1:0]     valid_q, valid_d;
    logic [L-1:0]     carry_q, carry_d;
    logic [WIDTH-1:0] opa_q [L];
    logic [WIDTH-1:0] opa_d [L];
    logic [WIDTH-1:0] opb_q [L];
    logic [WIDTH-1:0] opb_d [L];
    logic [WIDTH-1:0] sum_q [L];
    logic [WIDTH-1:0] sum_d [L];
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             adv_s, take_s, cin0_s;
    logic [WIDTH-1:0] bin_s;
    logic [SEG:0]     seg_r_s;

    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | ((&p) & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Look-ahead groups of four bits ripple their group carries across the slice.
    function automatic logic [SEG:0] add_seg(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                             input logic c);
        logic [SEG-1:0] s;
        logic           cg;
        logic [4:0]     r;
        s  = '0;
        cg = c;
        for (int g = 0; g < SEG / 4; g++) begin
            r            = cla4(x[g*4 +: 4], y[g*4 +: 4], cg);
            s[g*4 +: 4]  = r[3:0];
            cg           = r[4];
        end
        return {cg, s};
    endfunction

    // Handshake, slice arithmetic for every stage, and final-stage flags.
    always_comb begin
        adv_s    = ~valid_q[L-1] | out_ready;
        in_ready = rst_n & adv_s;
        take_s   = in_valid & in_ready;
        bin_s    = sub ? ~b : b;
        cin0_s   = sub | cin;
        valid_d  = valid_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        seg_r_s  = '0;
        for (int k = 0; k < L; k++) begin
            opa_d[k] = opa_q[k];
            opb_d[k] = opb_q[k];
            sum_d[k] = sum_q[k];
        end
        if (adv_s) begin
            seg_r_s                = add_seg(a[SEG-1:0], bin_s[SEG-1:0], cin0_s);
            valid_d[0]             = take_s;
            opa_d[0]               = a;
            opb_d[0]               = bin_s;
            sum_d[0]               = '0;
            sum_d[0][SEG-1:0]      = seg_r_s[SEG-1:0];
            carry_d[0]             = seg_r_s[SEG];
            for (int k = 1; k < L; k++) begin
                seg_r_s                 = add_seg(opa_q[k-1][k*SEG +: SEG],
                                                  opb_q[k-1][k*SEG +: SEG], carry_q[k-1]);
                valid_d[k]              = valid_q[k-1];
                opa_d[k]                = opa_q[k-1];
                opb_d[k]                = opb_q[k-1];
                sum_d[k]                = sum_q[k-1];
                sum_d[k][k*SEG +: SEG]  = seg_r_s[SEG-1:0];
                carry_d[k]              = seg_r_s[SEG];
            end
            ovf_d = (opa_d[L-1][WIDTH-1] == opb_d[L-1][WIDTH-1])
                  & (sum_d[L-1][WIDTH-1] != opa_d[L-1][WIDTH-1]);
`ifdef ADDSUB_SAT_EN
            sum_d[L-1] = ovf_d ? (opa_d[L-1][WIDTH-1] ? SAT_MIN : SAT_MAX) : sum_d[L-1];
`endif
            zero_d = (sum_d[L-1] == {WIDTH{1'b0}});
        end else begin
            valid_d = valid_q;
        end
    end

    // Pipeline registers; synchronous reset discards every beat in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            for (int k = 0; k < L; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            for (int k = 0; k < L; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign out_valid = valid_q[L-1];
    assign sum       = sum_q[L-1];
    assign cout      = carry_q[L-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand/result width in bits; SHALL be a multiple of SEG, minimum 8.
REQ-002 The block SHALL have parameter SEG, default 4: bits computed per pipeline stage (one 4-bit look-ahead group per SEG/4).
REQ-003 Port clk, input, width 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, width 1: reset, synchronous, active-low.
REQ-005 Port in_valid, input, width 1: operand beat present.
REQ-006 Port in_ready, output, width 1: the block accepts a beat this cycle.
REQ-007 Port a, input, width WIDTH: first operand.
REQ-008 Port b, input, width WIDTH: second operand.
REQ-009 Port sub, input, width 1: 1 = a-b (a + ~b + 1), 0 = a+b+cin.
REQ-010 Port cin, input, width 1: carry-in, used only when sub=0.
REQ-011 Port out_valid, output, width 1: result beat present.
REQ-012 Port out_ready, input, width 1: downstream accepts the result.
REQ-013 Port sum, output, width WIDTH: result.
REQ-014 Port cout, output, width 1: unsigned carry out of the MSB (for subtract, 1 = no borrow).
REQ-015 Port overflow, output, width 1: signed two's-complement overflow.
REQ-016 Port zero, output, width 1: sum == 0 (after saturation when enabled).

Function
REQ-017 Pipeline depth L = WIDTH/SEG stages; stage k SHALL add operand bits [k*SEG+SEG-1 : k*SEG] using the carry registered by stage k-1 (stage 0 uses cin, or 1 when sub=1).
REQ-018 Upper operand slices SHALL be carried forward through registers, and completed lower sum slices SHALL be carried forward, so that each beat's sum emerges aligned.
REQ-019 Latency SHALL be exactly L cycles from an accepted beat (in_valid & in_ready) to its out_valid, absent stalls.
REQ-020 Advance condition: adv = ~out_valid | out_ready. All stages SHALL shift together only when adv=1; otherwise every stage SHALL hold its contents.
REQ-021 in_ready SHALL equal adv, driven combinationally; a beat SHALL be captured only on in_valid & in_ready.
REQ-022 A stage SHALL shift in a bubble (valid=0) when stage 0 advances with no accepted beat; bubbles SHALL propagate as invalid and SHALL never raise out_valid.
REQ-023 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-024 sum, cout, overflow and zero SHALL be held stable while out_valid=1 and out_ready=0.
REQ-025 overflow SHALL be 1 iff the effective operands (a, and b or ~b) share a sign bit and sum[WIDTH-1] differs from it, evaluated before saturation.
REQ-026 Beats SHALL complete in order, with none dropped or duplicated under any out_ready pattern.

Reset
REQ-027 While rst_n=0 at a rising edge, all stage valid bits, out_valid, sum, cout, overflow and zero SHALL be cleared to 0.
REQ-028 During reset, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-029 A reset mid-operation SHALL discard all beats in flight; the first beat accepted after release SHALL appear after exactly L cycles.

Configuration
REQ-030 Macro ADDSUB_SAT_EN defined: on overflow, sum SHALL clamp to the most positive value (0x7FFF for WIDTH=16) when the operand sign is 0, and to the most negative value (0x8000) when it is 1; overflow SHALL still assert.
REQ-031 Macro ADDSUB_SAT_EN undefined: sum SHALL wrap modulo 2^WIDTH, and no clamp logic SHALL be present.

Verification (WIDTH=16, SEG=4, so L=4)
REQ-032 a=0x7FFF, b=0x0001, sub=0, cin=0 -> after 4 cycles: sum=0x8000 and overflow=1 (sum=0x7FFF when ADDSUB_SAT_EN is defined), cout=0.
REQ-033 a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, overflow=0, zero=0.
REQ-034 a=0xFFFF, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1, zero=1, overflow=0; the same operands with cin=1 -> sum=0x0001.
REQ-035 Back-to-back stream of 8 beats, with out_ready held low for 3 cycles starting on the first out_valid -> in_ready low for those 3 cycles, all 8 results in order, and outputs stable while stalled.
REQ-036 Accept 2 beats, then assert rst_n=0 for 1 cycle -> out_valid never asserts for them; a new beat accepted after release gives out_valid exactly 4 cycles later.
